job_scheduler: RTL and testbench

JOB_SCHEDULER -- requirements
Module: job_scheduler

---
 rtl/cad_pkg.sv | 21 ++
 rtl/job_scheduler_rr_arbiter2.sv | 18 +
 rtl/job_scheduler.sv | 138 +++++++++++++
 tb/tb_job_scheduler.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cad_pkg.sv
// Shared types and defaults for the job scheduler: FSM state encoding,
// operand/result width defaults, watchdog default and a grant helper.
package cad_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int ENTRY_W_DEF = 4;
  localparam int RES_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  // Index of the requester selected by a one-hot two-bit grant.
  function automatic logic grant_idx(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/job_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter. Combinational. When both requesters
// ask, the one that was not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/job_scheduler.sv
// Two-requester job scheduler feeding a single datapath. An optional
// watchdog on the datapath wait is enabled with `define JOB_SCHEDULER_TIMEOUT_EN.
module job_scheduler
  import cad_pkg::*;
#(
  parameter int ENTRY_W        = ENTRY_W_DEF,
  parameter int RES_W          = RES_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [ENTRY_W-1:0] entry0,
  input  logic [ENTRY_W-1:0] entry1,
  output logic [1:0]         ack,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [RES_W-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               dp_start,
  output logic [ENTRY_W-1:0] dp_entry,
  input  logic               dp_done,
  input  logic [RES_W-1:0]   dp_result,
  output logic               busy
);

  state_t     state;
  state_t     next_state;
  logic [1:0] grant;
  logic [1:0] grant_q;
  logic       rr_ptr;
  logic       accept;
  logic       timeout_hit;

  // rr_ptr names the requester that wins a tie; the arbiter wants the last one served.
  rr_arbiter2 u_arb (
    .req   (req),
    .last  (~rr_ptr),
    .grant (grant)
  );

  assign accept = (state == RESP) && (|(rsp_ready & grant_q));
  assign busy   = (state != IDLE);

`ifdef JOB_SCHEDULER_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // A completion in the same cycle as the limit wins over the timeout.
  assign timeout_hit = (state == WAIT) && !dp_done && (wait_cnt == TO_LAST);
  assign rsp_err     = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (dp_done || timeout_hit) next_state = RESP;
      RESP:    if (accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      grant_q   <= 2'b00;
      ack       <= 2'b00;
      dp_start  <= 1'b0;
      dp_entry  <= '0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
`ifdef JOB_SCHEDULER_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state    <= next_state;
      ack      <= 2'b00;
      dp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_q  <= grant;
            ack      <= grant;
            dp_entry <= grant_idx(grant) ? entry1 : entry0;
          end
        end
        ISSUE: begin
          dp_start <= 1'b1;
        end
        WAIT: begin
          if (dp_done) begin
            rsp_data  <= dp_result;
            rsp_valid <= grant_q;
`ifdef JOB_SCHEDULER_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end else if (timeout_hit) begin
            rsp_data  <= '1;
            rsp_valid <= grant_q;
`ifdef JOB_SCHEDULER_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
          end
        end
        RESP: begin
          if (accept) begin
            rsp_valid <= 2'b00;
            rr_ptr    <= ~grant_idx(grant_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_job_scheduler.sv
// Self-checking bench for job_scheduler with a datapath stub returning entry*3
// ten cycles after dp_start. Exercises the watchdog when JOB_SCHEDULER_TIMEOUT_EN is set.
module tb_job_scheduler;

  localparam int EW = 4;
  localparam int RW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [EW-1:0] entry0;
  logic [EW-1:0] entry1;
  logic [1:0]    ack;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [RW-1:0] rsp_data;
  logic          rsp_err;
  logic          dp_start;
  logic [EW-1:0] dp_entry;
  logic          dp_done;
  logic [RW-1:0] dp_result;
  logic          busy;

  logic          stub_active = 1'b0;
  int            stub_cnt    = 0;
  logic [EW-1:0] stub_ent    = '0;
  logic          stub_done   = 1'b0;
  logic [RW-1:0] stub_res    = '0;
  logic          stub_mute   = 1'b0;
  logic          spur_done   = 1'b0;

  typedef struct packed {
    logic [1:0]    who;
    logic [RW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  job_scheduler #(
    .ENTRY_W        (EW),
    .RES_W          (RW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .entry0    (entry0),
    .entry1    (entry1),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dp_start  (dp_start),
    .dp_entry  (dp_entry),
    .dp_done   (dp_done),
    .dp_result (dp_result),
    .busy      (busy)
  );

  assign dp_done   = (stub_done & ~stub_mute) | spur_done;
  assign dp_result = spur_done ? 8'hAA : stub_res;

  // Datapath stub: captures dp_entry on dp_start, answers entry*3 ten cycles later.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (stub_active) begin
      if (stub_cnt == 10) begin
        stub_done   <= 1'b1;
        stub_res    <= {4'b0000, stub_ent} * 8'd3;
        stub_active <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt + 1;
      end
    end else if (dp_start) begin
      stub_active <= 1'b1;
      stub_cnt    <= 1;
      stub_ent    <= dp_entry;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b0;
    req       = 2'b00;
    rsp_ready = 2'b00;
    spur_done = 1'b0;
    stub_mute = 1'b0;
    tick();
    for (int i = 0; i < 20 && stub_active; i++) tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_ack(output logic [1:0] got, output bit ok);
    ok  = 1'b0;
    got = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack != 2'b00) begin
        got = ack;
        ok  = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_dp_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dp_start) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output bit done_prev, output int acks);
    logic prev;
    ok        = 1'b0;
    done_prev = 1'b0;
    acks      = 0;
    prev      = dp_done;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack != 2'b00) acks++;
      if (rsp_valid != 2'b00) begin
        ok        = 1'b1;
        done_prev = prev;
        return;
      end
      prev = dp_done;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    req       = 2'b11;
    entry0    = 4'hF;
    entry1    = 4'hF;
    rsp_ready = 2'b11;
    tick();
    tick();
    vectors++;
    if ({ack, rsp_valid, rsp_data, rsp_err, dp_start, dp_entry, busy} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {ack, rsp_valid, rsp_data, rsp_err, dp_start, dp_entry, busy});
    end
    rsp_ready = 2'b00;
    rst       = 1'b1;
    tick();
    vectors++;
    if (ack !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL reset_priority: ack got %b, expected 01", ack);
    end
    req = 2'b00;
  endtask

  task automatic test_single_job;
    bit ok, dprev;
    int acks;
    do_reset();
    entry0 = 4'd6;
    req    = 2'b01;
    sb.push_back('{who: 2'b01, data: 8'd18, err: 1'b0});
    tick();
    vectors++;
    if ({ack, busy, dp_start} !== {2'b01, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL single_ack: ack/busy/start got %b, expected 01_1_0", {ack, busy, dp_start});
    end
    req = 2'b00;
    tick();
    vectors++;
    if ({dp_start, dp_entry, ack} !== {1'b1, 4'd6, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL single_start: start/entry/ack got %h, expected %h", {dp_start, dp_entry, ack}, {1'b1, 4'd6, 2'b00});
    end
    tick();
    vectors++;
    if (dp_start !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_start_pulse: dp_start got %b, expected 0", dp_start);
    end
    wait_rsp(40, ok, dprev, acks);
    e = sb.pop_front();
    vectors++;
    if (!ok || dprev !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_latency: seen %b done_prev %b, expected 1 1", ok, dprev);
    end
    vectors++;
    if ({rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL single_rsp: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    vectors++;
    if ({rsp_valid, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL single_accept: valid/busy got %b, expected 000", {rsp_valid, busy});
    end
  endtask

  task automatic test_simultaneous;
    bit ok, dprev;
    int acks;
    logic [1:0] got;
    do_reset();
    entry0 = 4'd2;
    entry1 = 4'd5;
    sb.push_back('{who: 2'b01, data: 8'd6,  err: 1'b0});
    sb.push_back('{who: 2'b10, data: 8'd15, err: 1'b0});
    sb.push_back('{who: 2'b01, data: 8'd6,  err: 1'b0});
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_ack(got, ok);
      vectors++;
      if (!ok || got !== sb[0].who) begin
        miscompares++;
        $display("[TB] FAIL simul_grant%0d: ack got %b, expected %b", k, got, sb[0].who);
      end
      req = req & ~got;
      wait_rsp(40, ok, dprev, acks);
      e = sb.pop_front();
      vectors++;
      if (!ok || acks != 0) begin
        miscompares++;
        $display("[TB] FAIL simul_overlap%0d: rsp seen %b, extra acks %0d, expected 1 0", k, ok, acks);
      end
      vectors++;
      if ({rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
        miscompares++;
        $display("[TB] FAIL simul_rsp%0d: got %h, expected %h", k, {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
      end
      rsp_ready = e.who;
      tick();
      rsp_ready = 2'b00;
      vectors++;
      if ({ack, busy} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL simul_accept_gap%0d: ack/busy got %b, expected 000", k, {ack, busy});
      end
      req = (k < 2) ? 2'b11 : 2'b00;
    end
  endtask

  task automatic test_back_pressure;
    bit ok, dprev;
    int acks;
    logic [1:0] got;
    do_reset();
    entry0 = 4'd6;
    req    = 2'b01;
    sb.push_back('{who: 2'b01, data: 8'd18, err: 1'b0});
    wait_ack(got, ok);
    req = 2'b00;
    wait_rsp(40, ok, dprev, acks);
    e = sb[0];
    vectors++;
    if (!ok || {rsp_valid, rsp_data} !== {e.who, e.data}) begin
      miscompares++;
      $display("[TB] FAIL bp_first_rsp: got %h, expected %h", {rsp_valid, rsp_data}, {e.who, e.data});
    end
    entry1    = 4'd4;
    req       = 2'b10;
    rsp_ready = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      vectors++;
      if ({rsp_valid, rsp_data, ack, busy} !== {e.who, e.data, 2'b00, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL bp_hold%0d: valid/data/ack/busy got %h, expected %h",
                 i, {rsp_valid, rsp_data, ack, busy}, {e.who, e.data, 2'b00, 1'b1});
      end
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    void'(sb.pop_front());
    vectors++;
    if ({rsp_valid, ack} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL bp_release: valid/ack got %b, expected 0000", {rsp_valid, ack});
    end
    sb.push_back('{who: 2'b10, data: 8'd12, err: 1'b0});
    wait_ack(got, ok);
    req = 2'b00;
    vectors++;
    if (!ok || got !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL bp_pending_grant: ack got %b, expected 10", got);
    end
    wait_rsp(40, ok, dprev, acks);
    e = sb.pop_front();
    vectors++;
    if (!ok || {rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL bp_second_rsp: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_wait;
    bit ok, dprev;
    int acks;
    int activity;
    logic [1:0] got;
    do_reset();
    entry1 = 4'd7;
    req    = 2'b10;
    wait_ack(got, ok);
    req = 2'b00;
    wait_dp_start(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL midwait_start: dp_start seen %b, expected 1", ok);
    end
    repeat (4) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({ack, rsp_valid, rsp_data, rsp_err, dp_start, dp_entry, busy} !== 19'd0) begin
      miscompares++;
      $display("[TB] FAIL midwait_reset_outputs: got %h, expected 0",
               {ack, rsp_valid, rsp_data, rsp_err, dp_start, dp_entry, busy});
    end
    rst      = 1'b1;
    activity = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid != 2'b00 || busy) activity++;
    end
    vectors++;
    if (activity != 0) begin
      miscompares++;
      $display("[TB] FAIL midwait_late_done: active cycles got %0d, expected 0", activity);
    end
    entry1 = 4'd3;
    req    = 2'b10;
    sb.push_back('{who: 2'b10, data: 8'd9, err: 1'b0});
    wait_ack(got, ok);
    req = 2'b00;
    vectors++;
    if (!ok || got !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL midwait_regrant: ack got %b, expected 10", got);
    end
    wait_rsp(40, ok, dprev, acks);
    e = sb.pop_front();
    vectors++;
    if (!ok || {rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL midwait_rsp: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_spurious_done;
    bit ok, dprev;
    int acks;
    do_reset();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    vectors++;
    if ({rsp_valid, ack, busy} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL spur_idle: valid/ack/busy got %b, expected 00000", {rsp_valid, ack, busy});
    end
    entry0 = 4'd1;
    req    = 2'b01;
    sb.push_back('{who: 2'b01, data: 8'd3, err: 1'b0});
    tick();
    req       = 2'b00;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    vectors++;
    if ({dp_start, rsp_valid, busy} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL spur_issue: start/valid/busy got %b, expected 1001", {dp_start, rsp_valid, busy});
    end
    wait_rsp(40, ok, dprev, acks);
    e = sb.pop_front();
    vectors++;
    if (!ok || {rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL spur_rsp: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
  endtask

  task automatic test_wait_limit;
    bit ok;
    int first_valid;
    logic [1:0] got;
    do_reset();
    stub_mute = 1'b1;
    entry0    = 4'd9;
    req       = 2'b01;
    wait_ack(got, ok);
    req = 2'b00;
    wait_dp_start(ok);
`ifdef JOB_SCHEDULER_TIMEOUT_EN
    sb.push_back('{who: 2'b01, data: 8'hFF, err: 1'b1});
    first_valid = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (rsp_valid != 2'b00 && first_valid == 0) first_valid = k;
    end
    vectors++;
    if (first_valid != TO) begin
      miscompares++;
      $display("[TB] FAIL timeout_cycle: rsp_valid rose after %0d, expected %0d", first_valid, TO);
    end
    e = sb.pop_front();
    vectors++;
    if ({rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL timeout_rsp: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    req = 2'b01;
    wait_ack(got, ok);
    req = 2'b00;
    wait_dp_start(ok);
    sb.push_back('{who: 2'b01, data: 8'hAA, err: 1'b0});
    repeat (TO - 1) tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL timeout_vs_done: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
`else
    first_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rsp_valid != 2'b00 && first_valid == 0) first_valid = k;
    end
    vectors++;
    if (first_valid != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wait_no_timeout: rsp_valid rose after %0d busy %b, expected 0 1", first_valid, busy);
    end
    sb.push_back('{who: 2'b01, data: 8'hAA, err: 1'b0});
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({rsp_valid, rsp_data, rsp_err} !== {e.who, e.data, e.err}) begin
      miscompares++;
      $display("[TB] FAIL wait_late_done: got %h, expected %h", {rsp_valid, rsp_data, rsp_err}, {e.who, e.data, e.err});
    end
`endif
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    stub_mute = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    req       = 2'b00;
    entry0    = '0;
    entry1    = '0;
    rsp_ready = 2'b00;
    test_reset();
    test_single_job();
    test_simultaneous();
    test_back_pressure();
    test_reset_mid_wait();
    test_spurious_done();
    test_wait_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
